// File: rtl/jogador_automatico.sv
// rtl/jogador_automatico.sv - auto-player replaying a stored button sequence round by round
// Optional wrong-play injection is compiled in by defining JOGADOR_ERRO_EN.
module jogador_automatico #(
  parameter int NBOTOES  = 4,
  parameter int NRODADAS = 16,
  parameter logic [NBOTOES*NRODADAS-1:0] SEQ = 64'h4188_4422_1124_8421,
  parameter int T_PAUSA  = 5,
  parameter int T_PRESS  = 5,
  parameter int T_SOLTA  = 5,
  localparam int RW = $clog2(NRODADAS+1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               pausa,
  input  logic [RW-1:0]      rodadas_max,
  input  logic [RW-1:0]      erro_rodada,
  output logic [NBOTOES-1:0] chaves,
  output logic [RW-1:0]      rodada,
  output logic [RW-1:0]      jogada,
  output logic               ocupado,
  output logic               fim,
  output logic               erro_injetado
);

  localparam int TP   = (T_PAUSA < 1) ? 1 : T_PAUSA;
  localparam int TPR  = (T_PRESS < 1) ? 1 : T_PRESS;
  localparam int TS   = (T_SOLTA < 1) ? 1 : T_SOLTA;
  localparam int TM1  = (TP > TPR) ? TP : TPR;
  localparam int TMAX = (TM1 > TS) ? TM1 : TS;
  localparam int TW   = $clog2(TMAX+1);

  typedef enum logic [2:0] {OCIOSO, ESPERA, PRESSIONA, SOLTA, FIM} estado_t;

  estado_t           estado, estado_n;
  logic [TW-1:0]     timer, timer_n;
  logic [RW-1:0]     rodada_n, jogada_n, max_r, max_r_n, max_cap;
  logic              inj_n;
  logic              injetar;
  logic [NBOTOES-1:0] entrada;

  always_comb begin
    max_cap = rodadas_max;
    if (rodadas_max == '0 || rodadas_max > RW'(NRODADAS))
      max_cap = RW'(NRODADAS);
  end

`ifdef JOGADOR_ERRO_EN
  logic [RW-1:0] erro_r;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      erro_r <= '0;
    else if (iniciar)
      erro_r <= erro_rodada;
  end

  // Corrupt only the last play of the selected round
  assign injetar = (erro_r != '0) && (rodada == erro_r) && (jogada == rodada - RW'(1));
`else
  logic unused_erro;
  assign unused_erro = ^erro_rodada;
  assign injetar     = 1'b0;
`endif

  assign entrada = SEQ[jogada*NBOTOES +: NBOTOES];

  always_comb begin
    chaves = '0;
    if (estado == PRESSIONA)
      chaves = injetar ? {entrada[NBOTOES-2:0], entrada[NBOTOES-1]} : entrada;
  end

  assign ocupado = (estado == ESPERA) || (estado == PRESSIONA) || (estado == SOLTA);
  assign fim     = (estado == FIM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado        <= OCIOSO;
      timer         <= '0;
      rodada        <= '0;
      jogada        <= '0;
      max_r         <= '0;
      erro_injetado <= 1'b0;
    end else begin
      estado        <= estado_n;
      timer         <= timer_n;
      rodada        <= rodada_n;
      jogada        <= jogada_n;
      max_r         <= max_r_n;
      erro_injetado <= inj_n;
    end
  end

  always_comb begin
    estado_n = estado;
    timer_n  = timer;
    rodada_n = rodada;
    jogada_n = jogada;
    max_r_n  = max_r;
    inj_n    = erro_injetado;
    // iniciar wins over pausa and over every state
    if (iniciar) begin
      estado_n = ESPERA;
      timer_n  = '0;
      rodada_n = RW'(1);
      jogada_n = '0;
      max_r_n  = max_cap;
      inj_n    = 1'b0;
    end else if (!pausa) begin
      case (estado)
        ESPERA: begin
          if (timer == TW'(TP-1)) begin
            timer_n  = '0;
            estado_n = PRESSIONA;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
        PRESSIONA: begin
          if (timer == TW'(TPR-1)) begin
            timer_n  = '0;
            estado_n = SOLTA;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
        SOLTA: begin
          if (timer == TW'(TS-1)) begin
            timer_n = '0;
            if (injetar) begin
              estado_n = FIM;
              inj_n    = 1'b1;
            end else if (jogada != rodada - RW'(1)) begin
              jogada_n = jogada + RW'(1);
              estado_n = PRESSIONA;
            end else if (rodada != max_r) begin
              rodada_n = rodada + RW'(1);
              jogada_n = '0;
              estado_n = ESPERA;
            end else begin
              estado_n = FIM;
            end
          end else begin
            timer_n = timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jogador_automatico.sv
// tb/tb_jogador_automatico.sv - scoreboard bench for jogador_automatico
module tb_jogador_automatico;
  localparam int NB = 4, NR = 16, RW = 5, TP = 5, TPR = 5, TS = 5;

  logic          clock = 1'b0;
  logic          reset, iniciar, pausa;
  logic [RW-1:0] rodadas_max, erro_rodada, rodada, jogada;
  logic [NB-1:0] chaves;
  logic          ocupado, fim, erro_injetado;

  jogador_automatico dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .pausa(pausa),
    .rodadas_max(rodadas_max), .erro_rodada(erro_rodada),
    .chaves(chaves), .rodada(rodada), .jogada(jogada),
    .ocupado(ocupado), .fim(fim), .erro_injetado(erro_injetado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [NB-1:0] ch;
    int            rod;
    int            jog;
    bit            is_fim;
    bit            err;
  } ev_t;

  ev_t         exp_q[$];
  int          n_cmp = 0, n_fail = 0;
  logic [63:0] seqv = 64'h4188_4422_1124_8421;

  task automatic chk(input bit ok, input string name, input string got, input string want);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, got, want);
    end
  endtask

  function automatic logic [NB-1:0] entry(input int j);
    return seqv[j*NB +: NB];
  endfunction

  // Expected presses and fim for one run started at edge k
  task automatic gen_run(input int k, input int maxr, input int erro);
    int  m, t;
    ev_t e;
    m = (maxr == 0 || maxr > NR) ? NR : maxr;
    t = k;
    e.err = 0;
    for (int r = 1; r <= m; r++) begin
      t += TP;
      for (int j = 0; j < r; j++) begin
        e.cyc = t; e.ch = entry(j); e.rod = r; e.jog = j; e.is_fim = 0; e.err = 0;
`ifdef JOGADOR_ERRO_EN
        if (erro == r && j == r - 1) begin
          e.ch  = {e.ch[NB-2:0], e.ch[NB-1]};
          e.err = 1;
        end
`endif
        exp_q.push_back(e);
        t += TPR + TS;
      end
      if (e.err) begin
        e.cyc = t; e.ch = '0; e.rod = r; e.jog = r - 1; e.is_fim = 1;
        exp_q.push_back(e);
        return;
      end
    end
    e.cyc = t; e.ch = '0; e.rod = m; e.jog = m - 1; e.is_fim = 1; e.err = 0;
    exp_q.push_back(e);
    if (erro < 0) $display("note: negative erro %0d", erro);
  endtask

  logic [NB-1:0] prev_ch = '0;
  logic          prev_fim = 1'b0;

  always @(negedge clock) begin
    ev_t e;
    if (chaves != '0 && chaves != prev_ch) begin
      if (exp_q.size() == 0)
        chk(0, "press_unexpected", $sformatf("%b at %0d", chaves, cyc), "no press");
      else begin
        e = exp_q.pop_front();
        chk(!e.is_fim && e.cyc == cyc && e.ch == chaves && e.rod == rodada &&
            e.jog == jogada && ocupado, "press",
            $sformatf("ch=%b cyc=%0d rod=%0d jog=%0d oc=%b", chaves, cyc, rodada, jogada, ocupado),
            $sformatf("ch=%b cyc=%0d rod=%0d jog=%0d oc=1 fimev=%b", e.ch, e.cyc, e.rod, e.jog, e.is_fim));
      end
    end
    if (fim && !prev_fim) begin
      if (exp_q.size() == 0)
        chk(0, "fim_unexpected", $sformatf("fim at %0d", cyc), "no fim");
      else begin
        e = exp_q.pop_front();
        chk(e.is_fim && e.cyc == cyc && e.rod == rodada && e.jog == jogada &&
            e.err == erro_injetado && !ocupado && chaves == '0, "fim",
            $sformatf("cyc=%0d rod=%0d jog=%0d err=%b oc=%b ch=%b", cyc, rodada, jogada, erro_injetado, ocupado, chaves),
            $sformatf("cyc=%0d rod=%0d jog=%0d err=%b oc=0 ch=0 fimev=%b", e.cyc, e.rod, e.jog, e.err, e.is_fim));
      end
    end
    prev_ch  = chaves;
    prev_fim = fim;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic start(input int maxr, input int erro, input int hold);
    int k;
    rodadas_max = maxr[RW-1:0];
    erro_rodada = erro[RW-1:0];
    iniciar     = 1'b1;
    k = cyc + 1;
    while (exp_q.size() > 0 && exp_q[$].cyc >= k) void'(exp_q.pop_back());
    for (int i = 1; i < hold; i++) tick();
    k = cyc + 1;
    gen_run(k, maxr, erro);
    tick();
    iniciar = 1'b0;
  endtask

  task automatic do_pause(input int len, input bit chk_en, input logic [NB-1:0] want);
    int p;
    p = cyc + 1;
    foreach (exp_q[i]) if (exp_q[i].cyc >= p) exp_q[i].cyc += len;
    pausa = 1'b1;
    repeat (len) tick();
    if (chk_en)
      chk(chaves == want, "pause_hold", $sformatf("%b", chaves), $sformatf("%b", want));
    pausa = 1'b0;
  endtask

  task automatic wait_drain(input int bound, input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      tick();
      n++;
    end
    chk(exp_q.size() == 0, name, $sformatf("%0d pending", exp_q.size()), "0 pending");
    exp_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, mx, er, hd;
    reset = 1'b0; iniciar = 1'b0; pausa = 1'b0; rodadas_max = '0; erro_rodada = '0;
    repeat (3) @(posedge clock);
    #2;
    chk({chaves, rodada, jogada, ocupado, fim, erro_injetado} == '0, "reset_state",
        $sformatf("ch=%b rod=%0d jog=%0d oc=%b fim=%b err=%b", chaves, rodada, jogada, ocupado, fim, erro_injetado),
        "all zero");
    reset = 1'b1;
    tick(); tick();
    chk(!ocupado && !fim, "idle", $sformatf("oc=%b fim=%b", ocupado, fim), "oc=0 fim=0");

    start(1, 0, 1);
    wait_drain(100, "run_max1");
    repeat (10) tick();
    chk(fim && !ocupado && chaves == '0 && rodada == 1, "fim_hold",
        $sformatf("fim=%b oc=%b ch=%b rod=%0d", fim, ocupado, chaves, rodada), "fim=1 oc=0 ch=0 rod=1");

    start(8, 0, 1);
    wait_drain(500, "run_max8");

    start(8, 0, 1);
    n = 0;
    while (rodada != 5 && n < 500) begin tick(); n++; end
    chk(rodada == 5, "reach_r5", $sformatf("%0d", rodada), "5");
    start(8, 0, 1);
    chk(rodada == 1 && jogada == 0 && ocupado, "restart",
        $sformatf("rod=%0d jog=%0d oc=%b", rodada, jogada, ocupado), "rod=1 jog=0 oc=1");
    wait_drain(500, "restart_run");

    start(8, 0, 1);
    repeat (6) tick();
    do_pause(7, 1'b1, 4'b0001);
    wait_drain(600, "pause_run");

    start(8, 2, 1);
    wait_drain(500, "erro_run");

    start(3, 0, 1);
    n = 0;
    while (chaves == '0 && n < 50) begin tick(); n++; end
    reset = 1'b0;
    #1;
    chk({chaves, rodada, jogada, ocupado, fim, erro_injetado} == '0, "async_reset",
        $sformatf("ch=%b rod=%0d jog=%0d oc=%b fim=%b err=%b", chaves, rodada, jogada, ocupado, fim, erro_injetado),
        "all zero");
    exp_q.delete();
    repeat (3) tick();
    reset = 1'b1;
    repeat (30) tick();
    chk(!ocupado && !fim && chaves == '0 && rodada == 0, "idle_after_reset",
        $sformatf("oc=%b fim=%b ch=%b rod=%0d", ocupado, fim, chaves, rodada), "oc=0 fim=0 ch=0 rod=0");

    for (int it = 0; it < 6; it++) begin
      mx = $urandom_range(0, 20);
      er = $urandom_range(0, 10);
      hd = $urandom_range(1, 3);
      start(mx, er, hd);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 150)) tick();
        do_pause($urandom_range(1, 12), 1'b0, '0);
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 100)) tick();
        start($urandom_range(1, 6), $urandom_range(0, 6), 1);
      end
      wait_drain(3000, "random_run");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
